// File: rtl/uart_rx_word.sv
// uart_rx_word: 8N1 UART receiver that pairs bytes into 14-bit words {hi[5:0],lo[7:0]}.
// Define UART_RX_PARITY_EN for 8E1 frames with even-parity checking.
module uart_rx_word #(
  parameter int CLKS_PER_BIT = 2170,
  parameter int TMO_BITS     = 40
) (
  input  logic        clk_adc,
  input  logic        RESET,
  input  logic        rx_in,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic [13:0] word_data,
  output logic        word_valid,
  output logic        frame_err,
  output logic        sync_err,
  output logic        parity_err,
  output logic        busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TMO_BITS * CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] TMO_LIM = TW'(TMO_BITS * CLKS_PER_BIT);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t          state_q;
  logic            s1_q, s2_q, prev_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      sh_q;
  logic [5:0]      hi_q;
  logic            lo_phase_q;
  logic [TW-1:0]   tmo_q;
  logic            bad_q;
  logic            fall, last;
  assign fall = prev_q & ~s2_q;
  assign last = cnt_q == LAST;
  assign busy = state_q != IDLE;
  always_ff @(posedge clk_adc or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      prev_q     <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      hi_q       <= '0;
      lo_phase_q <= 1'b0;
      tmo_q      <= '0;
      bad_q      <= 1'b0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      word_data  <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      sync_err   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      s1_q       <= rx_in;
      s2_q       <= s1_q;
      prev_q     <= s2_q;
      byte_valid <= 1'b0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      sync_err   <= 1'b0;
      parity_err <= 1'b0;
      cnt_q      <= cnt_q + 1'b1;
      // The low byte must start within the timeout window; the count only runs between frames.
      if (lo_phase_q && state_q == IDLE && tmo_q != TMO_LIM) tmo_q <= tmo_q + 1'b1;
      if (lo_phase_q && state_q == IDLE && tmo_q == TMO_LIM && !fall) lo_phase_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (fall) state_q <= START;
        end
        START: if (cnt_q == HALF) begin
          cnt_q   <= '0;
          bit_q   <= '0;
          state_q <= s2_q ? IDLE : DATA;
        end
        DATA: if (last) begin
          cnt_q <= '0;
          sh_q  <= {s2_q, sh_q[7:1]};
          bit_q <= bit_q + 1'b1;
          if (bit_q == 3'd7) state_q <= AFTER_DATA;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (last) begin
          cnt_q      <= '0;
          state_q    <= STOP;
          bad_q      <= ^sh_q ^ s2_q;
          parity_err <= ^sh_q ^ s2_q;
          if (^sh_q ^ s2_q) lo_phase_q <= 1'b0;
        end
`endif
        STOP: if (last) begin
          cnt_q <= '0;
          bad_q <= 1'b0;
          if (!s2_q) begin
            frame_err  <= 1'b1;
            lo_phase_q <= 1'b0;
            state_q    <= WAIT_IDLE;
          end else begin
            state_q <= IDLE;
            if (!bad_q) begin
              byte_data  <= sh_q;
              byte_valid <= 1'b1;
              if (!lo_phase_q) begin
                if (sh_q[7:6] == 2'b00) begin
                  hi_q       <= sh_q[5:0];
                  lo_phase_q <= 1'b1;
                  tmo_q      <= '0;
                end else sync_err <= 1'b1;
              end else begin
                word_data  <= {hi_q, sh_q};
                word_valid <= 1'b1;
                lo_phase_q <= 1'b0;
              end
            end
          end
        end
        WAIT_IDLE: begin
          if (!s2_q) cnt_q <= '0;
          else if (last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word: directed-frame bench for uart_rx_word at CLKS_PER_BIT=16, TMO_BITS=4.
module tb_uart_rx_word;
  localparam int CPB = 16;
  logic        clk_adc = 1'b0;
  logic        RESET = 1'b0;
  logic        rx_in = 1'b1;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [13:0] word_data;
  logic        word_valid;
  logic        frame_err, sync_err, parity_err, busy;
  int n_chk = 0, n_pass = 0;
  int n_byte, n_word, n_ferr, n_serr, n_perr, viol;
  logic [13:0] last_word;
  logic [7:0]  serr_byte;
  logic [7:0]  bq[$];
  logic        prev_any = 1'b0;
  uart_rx_word #(.CLKS_PER_BIT(CPB), .TMO_BITS(4)) dut (
    .clk_adc(clk_adc), .RESET(RESET), .rx_in(rx_in),
    .byte_data(byte_data), .byte_valid(byte_valid),
    .word_data(word_data), .word_valid(word_valid),
    .frame_err(frame_err), .sync_err(sync_err), .parity_err(parity_err), .busy(busy)
  );
  always #5 clk_adc = ~clk_adc;
  always @(negedge clk_adc) begin
    logic any;
    any = byte_valid | word_valid | frame_err | sync_err | parity_err;
    if (byte_valid) begin n_byte++; bq.push_back(byte_data); end
    if (word_valid) begin n_word++; last_word = word_data; if (!byte_valid) viol++; end
    if (sync_err) begin n_serr++; serr_byte = byte_data; end
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if (any && prev_any) viol++;
    prev_any = any;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk_adc); #1; end
  endtask
  task automatic clr();
    n_byte = 0; n_word = 0; n_ferr = 0; n_serr = 0; n_perr = 0;
    bq.delete();
  endtask
  task automatic send(input logic [7:0] b, input logic stop = 1'b1, input logic bad_par = 1'b0);
    rx_in = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin rx_in = b[i]; tick(CPB); end
`ifdef UART_RX_PARITY_EN
    rx_in = ^b ^ bad_par; tick(CPB);
`endif
    rx_in = stop; tick(CPB);
    rx_in = 1'b1;
  endtask
  initial begin
    int quiet;
    clr(); viol = 0; last_word = '0; serr_byte = '0;
    tick(3);
    check("rst_byte", byte_data, 8'h00);
    check("rst_word", word_data, 14'h0000);
    check("rst_flags", {byte_valid, word_valid, frame_err, sync_err, parity_err, busy}, 6'b0);
    RESET = 1'b1;
    quiet = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if ({byte_valid, word_valid, frame_err, sync_err, parity_err, busy} != 6'b0) quiet++;
    end
    check("idle_quiet", quiet, 0);
    check("idle_word", word_data, 14'h0000);
    clr(); send(8'h05); send(8'hA3); tick(20);
    check("t2_nbyte", n_byte, 2);
    check("t2_b0", bq.size() > 0 ? bq[0] : 8'hxx, 8'h05);
    check("t2_b1", bq.size() > 1 ? bq[1] : 8'hxx, 8'hA3);
    check("t2_nword", n_word, 1);
    check("t2_word", last_word, 14'h05A3);
    check("t2_errs", n_ferr + n_serr + n_perr, 0);
    clr(); send(8'hC1); send(8'h12); send(8'h34); tick(20);
    check("t3_nbyte", n_byte, 3);
    check("t3_nserr", n_serr, 1);
    check("t3_serr_byte", serr_byte, 8'hC1);
    check("t3_nword", n_word, 1);
    check("t3_word", last_word, 14'h1234);
    clr(); send(8'h12, 1'b0); tick(10);
    check("t4_busy_hold", busy, 1);
    tick(20);
    check("t4_busy_rel", busy, 0);
    check("t4_nferr", n_ferr, 1);
    check("t4_nbyte", n_byte, 0);
    send(8'h00); send(8'h01); tick(20);
    check("t4_nword", n_word, 1);
    check("t4_word", last_word, 14'h0001);
    clr(); rx_in = 1'b0; tick(4);
    check("t5_busy_start", busy, 1);
    tick(1); rx_in = 1'b1; tick(7);
    check("t5_busy_end", busy, 0);
    tick(40);
    check("t5_strobes", n_byte + n_word + n_ferr + n_serr + n_perr, 0);
    clr(); send(8'h01); tick(100); send(8'h02); send(8'h03); tick(20);
    check("t6_nbyte", n_byte, 3);
    check("t6_nword", n_word, 1);
    check("t6_word", last_word, 14'h0203);
`ifdef UART_RX_PARITY_EN
    clr(); send(8'h04); send(8'h03, 1'b1, 1'b1); tick(20);
    check("t7_nperr", n_perr, 1);
    check("t7_nword", n_word, 0);
    check("t7_nbyte", n_byte, 1);
`endif
    check("strobe_rules", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
